// File: rtl/mem_pkg.sv
// Shared types for the memory-bus arbiter: operand width, FSM states and port ids.
package mem_pkg;

  typedef logic [31:0] RV32I_OPERAND_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } ARB_STATE_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_LSU   = 1'b1
  } ARB_PORT_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; a tie goes to the port not granted last.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_gnt;

  always_comb begin
    gnt = 2'b00;
    if (en && !rst) begin
      if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Reset value 1 hands the first tie to port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_gnt <= 1'b1;
    else if (|gnt) last_gnt <= gnt[1];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory_controller bus between the fetch and load/store ports;
// each grant becomes a fixed-length bus access followed by a one-cycle response.
module mem_bus_arbiter
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_req,
  input  logic           m1_req,
  input  RV32I_OPERAND_t m0_addr,
  input  RV32I_OPERAND_t m1_addr,
  input  RV32I_OPERAND_t m0_wrdata,
  input  RV32I_OPERAND_t m1_wrdata,
  input  logic           m0_wren,
  input  logic           m1_wren,
  output logic           m0_gnt,
  output logic           m1_gnt,
  output logic           m0_rvalid,
  output logic           m1_rvalid,
  output RV32I_OPERAND_t m0_rddata,
  output RV32I_OPERAND_t m1_rddata,
  output RV32I_OPERAND_t bus_addr,
  output RV32I_OPERAND_t bus_wrdata,
  output logic           bus_wren,
  input  RV32I_OPERAND_t bus_rddata,
  output logic           busy
);

  localparam int CNT_W = $clog2(RD_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  ARB_STATE_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  RV32I_OPERAND_t txn_addr, txn_wrdata;
  logic           txn_wren;
  ARB_PORT_t      txn_owner;
  logic [1:0]     gnt;
  logic           last_beat;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (state == IDLE),
    .req ({m1_req, m0_req}),
    .gnt (gnt)
  );

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign last_beat = (state == ACCESS) && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt) state_nxt = ACCESS;
      ACCESS:  if (cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction latch; cnt runs up to RD_LATENCY at most, which CNT_W holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_addr   <= '0;
      txn_wrdata <= '0;
      txn_wren   <= 1'b0;
      txn_owner  <= PORT_FETCH;
      cnt        <= '0;
    end else if (|gnt) begin
      txn_addr   <= gnt[1] ? m1_addr   : m0_addr;
      txn_wrdata <= gnt[1] ? m1_wrdata : m0_wrdata;
      txn_wren   <= gnt[1] ? m1_wren   : m0_wren;
      txn_owner  <= gnt[1] ? PORT_LSU  : PORT_FETCH;
      cnt        <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rddata <= '0;
      m1_rddata <= '0;
    end else begin
      m0_rvalid <= last_beat && (txn_owner == PORT_FETCH);
      m1_rvalid <= last_beat && (txn_owner == PORT_LSU);
      if (last_beat && (txn_owner == PORT_FETCH)) m0_rddata <= bus_rddata;
      if (last_beat && (txn_owner == PORT_LSU))   m1_rddata <= bus_rddata;
    end
  end

  // Combinational so that reset drops the write strobe without waiting for a clock.
  assign bus_addr   = txn_addr;
  assign bus_wrdata = txn_wrdata;
  assign bus_wren   = (state == ACCESS) && txn_wren && (cnt == '0);
  assign busy       = (state == ACCESS);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios plus random two-port traffic
// against a word-indexed memory model and a transaction-level reference.
module tb_mem_bus_arbiter;
  import mem_pkg::*;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req, m1_req, m0_wren, m1_wren;
  logic [31:0] m0_addr, m1_addr, m0_wrdata, m1_wrdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bus_wren, busy;
  logic [31:0] m0_rddata, m1_rddata, bus_addr, bus_wrdata, bus_rddata;

  mem_bus_arbiter #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wrdata(m0_wrdata), .m1_wrdata(m1_wrdata),
    .m0_wren(m0_wren), .m1_wren(m1_wren),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rddata(m0_rddata), .m1_rddata(m1_rddata),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_wren(bus_wren),
    .bus_rddata(bus_rddata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory behind the bus: 16 words selected by addr[5:2]; unwritten words have fixed contents.
  function automatic logic [31:0] init_val(input logic [3:0] i);
    return (i == 4'd2) ? 32'hDEADBEEF : (32'h1000_0000 + {28'd0, i} * 32'h0101_0101);
  endfunction

  logic [15:0] written = '0;
  logic [31:0] bus_mem [16];
  assign bus_rddata = written[bus_addr[5:2]] ? bus_mem[bus_addr[5:2]] : init_val(bus_addr[5:2]);
  always @(posedge clk) begin
    if (bus_wren) begin
      bus_mem[bus_addr[5:2]] <= bus_wrdata;
      written[bus_addr[5:2]] <= 1'b1;
    end
  end

  // Reference: transactions execute one at a time in grant order.
  typedef struct { logic wr; logic [31:0] data; int gcyc; } exp_t;
  exp_t q0[$], q1[$];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input int i);
    logic [3:0] k;
    k = i[3:0];
    return ref_mem.exists(i) ? ref_mem[i] : init_val(k);
  endfunction

  task automatic push(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
    exp_t e;
    int idx;
    idx = int'(a[5:2]);
    e.wr = w;
    e.gcyc = cyc;
    e.data = ref_rd(idx);
    if (w) ref_mem[idx] = d;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Monitor: arbitration rule, bus activity and responses against the reference.
  bit          inflight = 0;
  bit          last_m = 1;
  logic [31:0] cur_addr = '0, cur_wd = '0;
  logic        cur_wr = 1'b0;
  int          cur_g = -100;
  logic [31:0] prev0 = '0, prev1 = '0;
  logic [1:0]  eg;
  exp_t        em;

  always @(negedge clk) begin
    if (rst) begin
      inflight = 0; last_m = 1; q0.delete(); q1.delete();
      cur_addr = '0; cur_wd = '0; cur_wr = 1'b0; cur_g = -100;
    end else begin
      if (m0_rvalid) begin
        if (q0.size() == 0) check("m0_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          em = q0.pop_front();
          check("m0_rvalid_cycle", cyc, em.gcyc + LAT + 1);
          if (!em.wr) check("m0_rddata", m0_rddata, em.data);
        end
      end else check("m0_rddata_hold", m0_rddata, prev0);
      if (m1_rvalid) begin
        if (q1.size() == 0) check("m1_rvalid_unexpected", 32'd1, 32'd0);
        else begin
          em = q1.pop_front();
          check("m1_rvalid_cycle", cyc, em.gcyc + LAT + 1);
          if (!em.wr) check("m1_rddata", m1_rddata, em.data);
        end
      end else check("m1_rddata_hold", m1_rddata, prev1);
      if (m0_rvalid || m1_rvalid) begin
        check("rvalid_pair", {31'd0, inflight}, 32'd1);
        inflight = 0;
      end
      check("busy", {31'd0, busy}, {31'd0, inflight});
      check("bus_addr", bus_addr, cur_addr);
      check("bus_wren", {31'd0, bus_wren}, {31'd0, inflight && cur_wr && (cyc == cur_g + 1)});
      if (bus_wren || !inflight) check("bus_wrdata", bus_wrdata, cur_wd);
      eg = 2'b00;
      if (!inflight) begin
        if (m0_req && m1_req) eg = last_m ? 2'b01 : 2'b10;
        else                  eg = {m1_req, m0_req};
      end
      check("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
      if (|eg) begin
        last_m   = eg[1];
        inflight = 1;
        cur_g    = cyc;
        cur_addr = eg[1] ? m1_addr   : m0_addr;
        cur_wd   = eg[1] ? m1_wrdata : m0_wrdata;
        cur_wr   = eg[1] ? m1_wren   : m0_wren;
      end
    end
    prev0 = m0_rddata;
    prev1 = m1_rddata;
  end

  // Stimulus side: one clock per step; grants are pushed to the scoreboard as they are seen.
  bit g0, g1;

  task automatic step();
    g0 = 0; g1 = 0;
    @(negedge clk);
    if (m0_gnt) begin push(0, m0_addr, m0_wren, m0_wrdata); g0 = 1; end
    if (m1_gnt) begin push(1, m1_addr, m1_wren, m1_wrdata); g1 = 1; end
    @(posedge clk);
    #1;
    if (g0) m0_req = 1'b0;
    if (g1) m1_req = 1'b0;
  endtask

  task automatic drive(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
    if (p == 0) begin m0_req = 1'b1; m0_addr = a; m0_wren = w; m0_wrdata = d; end
    else        begin m1_req = 1'b1; m1_addr = a; m1_wren = w; m1_wrdata = d; end
  endtask

  task automatic issue(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
    int t;
    bit got;
    drive(p, a, w, d);
    t = 0; got = 0;
    while (!got && t < 40) begin
      step();
      got = (p == 0) ? g0 : g1;
      t++;
    end
    if (!got) check("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic settle();
    repeat (LAT + 2) step();
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    int n;
    int last_c;
    m0_req = 1'b1; m1_req = 1'b1; m0_wren = 1'b0; m1_wren = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wrdata = '0; m1_wrdata = '0;
    repeat (2) @(negedge clk);
    check("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    check("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bus_wren", {31'd0, bus_wren}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wrdata", bus_wrdata, 32'd0);
    check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check("rst_m0_rddata", m0_rddata, 32'd0);
    check("rst_m1_rddata", m1_rddata, 32'd0);
    @(posedge clk);
    #1;
    m0_req = 1'b0; m1_req = 1'b0;
    rst = 1'b0;

    issue(0, 32'h0040_0008, 1'b0, 32'h0);
    settle();

    // Both ports keep re-requesting: grants must alternate.
    drive(0, 32'h0000_0100, 1'b0, 32'h0);
    drive(1, 32'h0000_0204, 1'b0, 32'h0);
    for (int i = 0; i < 8 * (LAT + 1); i++) begin
      step();
      if (g0) drive(0, 32'h0000_0100 + 32'(i * 4), 1'b0, 32'h0);
      if (g1) drive(1, 32'h0000_0200 + 32'(i * 4), 1'b0, 32'h0);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    settle();

    issue(1, 32'h1001_0004, 1'b1, 32'h1234_5678);
    settle();
    issue(0, 32'h1001_0004, 1'b0, 32'h0);
    settle();

    // Fetch at cycle 0, LSU request raised at cycle 2 waits for the response cycle.
    drive(0, 32'h0000_0030, 1'b0, 32'h0);
    step();
    check("lat_fetch_gnt", {31'd0, g0}, 32'd1);
    step();
    drive(1, 32'h0000_0034, 1'b0, 32'h0);
    n = 0;
    do begin step(); n++; end while (!g1 && n < 20);
    check("lsu_wait_steps", n, LAT);
    settle();

    // LSU alone, back to back with incrementing addresses.
    last_c = 0;
    for (int k = 0; k < 8; k++) begin
      issue(1, 32'h0000_0040 + 32'(k * 4), 1'b0, 32'h0);
      if (k > 0) check("b2b_spacing", cyc - 1 - last_c, LAT + 1);
      last_c = cyc - 1;
    end
    settle();

    for (int i = 0; i < 1500; i++) begin
      step();
      if (!m0_req && ($urandom % 3 != 0)) drive(0, rnd_addr(), ($urandom % 3 == 0), $urandom);
      if (!m1_req && ($urandom % 3 != 0)) drive(1, rnd_addr(), ($urandom % 3 == 0), $urandom);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    settle();

    // Reset in the write strobe cycle of an LSU write.
    drive(1, 32'h1001_0004, 1'b1, 32'hCAFE_0001);
    step();
    check("wr_gnt_before_rst", {31'd0, g1}, 32'd1);
    #2;
    check("wren_before_rst", {31'd0, bus_wren}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_bus_wren", {31'd0, bus_wren}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_bus_addr", bus_addr, 32'd0);
    check("rst_mid_bus_wrdata", bus_wrdata, 32'd0);
    check("rst_mid_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    check("rst_mid_m0_rddata", m0_rddata, 32'd0);
    check("rst_mid_m1_rddata", m1_rddata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (LAT + 3) step();
    drive(0, 32'h0000_0020, 1'b0, 32'h0);
    drive(1, 32'h0000_0024, 1'b0, 32'h0);
    step();
    check("post_rst_tie", {30'd0, g1, g0}, 32'd1);
    n = 0;
    while (m1_req && n < 20) begin step(); n++; end
    check("post_rst_m1_served", {31'd0, m1_req}, 32'd0);
    settle();
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port round-robin arbiter and access sequencer placed in front of `memory_controller`. It lets the instruction-fetch port and the load/store port share that controller's single bus. Each accepted request becomes one bus transaction of fixed length, followed by a one-cycle response pulse to the winning port. It is the step from single-cycle to multi-cycle/pipelined cores, where fetch and data accesses contend for the same bus.

## Interface
Parameters:
- `RD_LATENCY`, default 1: cycles the bus address is held before `bus_rddata` is sampled; legal values ≥ 1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`, `m1_req`  in  1 each  request; port 0 is fetch, port 1 is load/store.
- `m0_addr`, `m1_addr`  in  `RV32I_OPERAND_t`  byte address.
- `m0_wrdata`, `m1_wrdata`  in  `RV32I_OPERAND_t`  write data.
- `m0_wren`, `m1_wren`  in  1 each  1 = write, 0 = read.
- `m0_gnt`, `m1_gnt`  out  1 each  request accepted this cycle (combinational).
- `m0_rvalid`, `m1_rvalid`  out  1 each  one-cycle response pulse; also marks write completion.
- `m0_rddata`, `m1_rddata`  out  `RV32I_OPERAND_t`  registered read data.
- `bus_addr`, `bus_wrdata`  out  `RV32I_OPERAND_t`  to `memory_controller`.
- `bus_wren`  out  1  to `memory_controller`.
- `bus_rddata`  in  `RV32I_OPERAND_t`  from `memory_controller`.
- `busy`  out  1  FSM in ACCESS.

## Operation
- FSM states, `ARB_STATE_t`: IDLE and ACCESS.
- IDLE, no request: all `gnt` are 0; stay in IDLE.
- IDLE, one request: that port is granted.
- IDLE, both requests: the port not granted last wins.
- `last_gnt` register: 1 bit, updated on every grant. Its reset value is 1, so port 0 wins the first tie.
- On a grant, at the same rising edge:
  - latch `addr`, `wrdata` and `wren` into `txn_addr`, `txn_wrdata` and `txn_wren`;
  - latch the owner into `txn_owner`;
  - set `cnt` to 0 and go to ACCESS.
- ACCESS:
  - `bus_addr` = `txn_addr`; `bus_wrdata` = `txn_wrdata`.
  - `bus_wren` = `txn_wren` AND (`cnt` == 0), so each write is exactly one cycle wide.
  - `cnt` increments each cycle.
- Leaving ACCESS, on the edge where `cnt` == `RD_LATENCY`−1:
  - the owner's `rddata` is loaded with `bus_rddata`;
  - the owner's `rvalid` is set for one cycle;
  - go to IDLE.
- Writes also load `rddata` (value unspecified). Masters ignore it for writes.
- `rddata` of the non-owner holds its previous value.
- Requests raised during ACCESS are not granted; they wait for IDLE.
- Masters must hold `req`, `addr`, `wrdata` and `wren` stable until `gnt` is seen. `req` may drop the cycle after `gnt`.
- A port may request again in the same cycle its `rvalid` is high. It competes normally.
- `cnt` width is `$clog2(RD_LATENCY+1)`. `cnt` never wraps inside one transaction.
- Bus outputs in IDLE:
  - `bus_addr` and `bus_wrdata` hold the last `txn_*` values;
  - `bus_wren` is 0.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, `last_gnt` 1, all `txn_*` 0;
  - `bus_addr` 0, `bus_wrdata` 0, `bus_wren` 0;
  - `m*_rvalid` 0, `m*_rddata` 0, `busy` 0;
  - `m*_gnt` 0 while `rst` is high.
- Latency: grant in cycle 0, bus active in cycles 1..`RD_LATENCY`, `rvalid` in cycle `RD_LATENCY`+1.
- Peak throughput: one transaction every `RD_LATENCY`+1 cycles.
- Reset asserted mid-ACCESS:
  - the transaction is dropped with no `rvalid`;
  - `bus_wren` goes low immediately (asynchronously).
- `gnt` is combinational from `req`, state and `last_gnt`. There is no path from `bus_rddata` to any `gnt`.

## Structure
- `mem_pkg` gets:
  - `ARB_STATE_t` (IDLE, ACCESS);
  - `ARB_PORT_t` (PORT_FETCH = 0, PORT_LSU = 1).
- Types come from `RV32I_defines.sv` / `fe_pkg` (`RV32I_OPERAND_t`).
- One natural sub-module, `rr_arbiter2`: 2-request round-robin picker with the `last_gnt` register, enabled only in IDLE.
- The sequencing FSM, latches and response registers stay in the top level.

## Test plan
- **Single fetch read** (`RD_LATENCY`=1): `m0_req`, `m0_addr`=0x00400008; bus model returns 0xDEADBEEF.
  - Required: `m0_gnt` in cycle 0, `bus_addr`=0x00400008 in cycle 1.
  - Required: `m0_rvalid`=1 and `m0_rddata`=0xDEADBEEF in cycle 2; `m1_rvalid` stays 0.
- **Contention**: both `req` held high for 8 cycles after reset.
  - Required: grants alternate m0, m1, m0, m1, one every 2 cycles.
- **Write**: `m1_wren`=1, `m1_addr`=0x10010004, `m1_wrdata`=0x12345678, `RD_LATENCY`=3.
  - Required: `bus_wren` high for exactly 1 cycle (cycle 1) with that address and data.
  - Required: `m1_rvalid` in cycle 4.
- **Latency 3 read**: `m0_req` at cycle 0.
  - Required: `busy` high in cycles 1–3, `m0_rvalid` in cycle 4.
  - Required: a `m1_req` raised at cycle 2 is granted in cycle 4.
- **Reset mid-ACCESS**: `rst` pulsed in cycle 1 of a write.
  - Required: `bus_wren` drops in the same cycle, no `rvalid` is produced, all outputs return to their reset values.
- **Back-to-back LSU only**: `m1_req` held high with incrementing addresses.
  - Required: one `m1_rvalid` every `RD_LATENCY`+1 cycles, with data in request order.
